// File: rtl/bus_mux_arbiter.sv
// bus_mux_arbiter
//   Round-robin owner selection for the N:1 data mux that drives the CPU
//   internal bus. One requester owns the mux at a time; it streams words
//   with a valid/ready handshake until it drops req or reaches MAX_HOLD
//   transfers. The search pointer then moves past it. Every release is
//   followed by one idle cycle with grant=0.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   req        per-requester request, held while the requester has data
//   data_in    packed requester data, requester i at [i*DATA_W +: DATA_W]
//   bus_ready  consumer accepts the word this cycle
//   grant      registered one-hot owner
//   sel        registered binary owner index (mux select)
//   bus_out    selected data word, 0 when nobody owns the bus
//   bus_valid  bus_out is valid (owner still requesting)
//   ack        one-hot single-cycle pulse to the owner on acceptance

// Per-requester slice: gates one data word and handshake onto the shared bus.
module bma_lane #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2,
  parameter int IDX    = 0
) (
  input  logic              own,
  input  logic [SEL_W-1:0]  sel,
  input  logic              req_bit,
  input  logic              bus_ready,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] data_gated,
  output logic              valid_bit,
  output logic              ack_bit
);
  logic hit;

  assign hit        = own && (sel == SEL_W'(IDX));
  assign data_gated = hit ? data : '0;
  assign valid_bit  = hit && req_bit;
  assign ack_bit    = valid_bit && bus_ready;
endmodule

module bus_mux_arbiter #(
  parameter int N_REQ    = 4,
  parameter int SEL_W    = 2,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] data_in,
  input  logic                    bus_ready,
  output logic [N_REQ-1:0]        grant,
  output logic [SEL_W-1:0]        sel,
  output logic [DATA_W-1:0]       bus_out,
  output logic                    bus_valid,
  output logic [N_REQ-1:0]        ack
);
  typedef enum logic {IDLE, OWN} state_t;

  state_t                           state;
  logic   [SEL_W-1:0]               ptr;
  logic   [3:0]                     hold_cnt;
  logic                             own;
  logic                             xfer;
  logic                             rel;
  logic   [SEL_W-1:0]               win;
  logic   [SEL_W-1:0]               idx;
  logic                             found;
  logic   [N_REQ-1:0][DATA_W-1:0]   lane_data;
  logic   [N_REQ-1:0]               lane_valid;

  assign own = (state == OWN);

  // Lane array: only the lane matching sel passes data, so the bus word is
  // a plain OR of all lanes.
  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    bma_lane #(.DATA_W(DATA_W), .SEL_W(SEL_W), .IDX(i)) u_lane (
      .own       (own),
      .sel       (sel),
      .req_bit   (req[i]),
      .bus_ready (bus_ready),
      .data      (data_in[i*DATA_W +: DATA_W]),
      .data_gated(lane_data[i]),
      .valid_bit (lane_valid[i]),
      .ack_bit   (ack[i])
    );
  end

  always_comb begin
    bus_out = '0;
    for (int i = 0; i < N_REQ; i++) bus_out = bus_out | lane_data[i];
  end

  assign bus_valid = |lane_valid;
  assign xfer      = bus_valid && bus_ready;
  // Owner leaves when it stops requesting or its last allowed word goes out.
  assign rel       = !req[sel] || (xfer && (hold_cnt == 4'(MAX_HOLD - 1)));

  // Rotating scan starting at ptr; SEL_W-bit addition wraps modulo N_REQ.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ptr + SEL_W'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      sel      <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state    <= OWN;
            grant    <= {{(N_REQ-1){1'b0}}, 1'b1} << win;
            sel      <= win;
            hold_cnt <= '0;
          end
        end
        OWN: begin
          if (rel) begin
            // sel is kept; ptr moves just past the departing owner.
            state <= IDLE;
            grant <= '0;
            ptr   <= sel + SEL_W'(1);
          end else if (xfer) begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end
endmodule

// File: doc/bus_mux_arbiter.md
Name: bus_mux_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared N:1 data multiplexer that feeds the CPU internal bus.
- Takes request lines from up to N_REQ requesters, picks one owner, and drives the mux select.
- Presents the selected data to the bus with a valid/ready handshake.
- Enforces fairness through a rotating priority pointer and a per-grant transfer limit.

Parameters:
- N_REQ, 4, number of requesters (power of two, 2..8).
- SEL_W, 2, select width, equal to log2(N_REQ).
- DATA_W, 8, width of each requester data word.
- MAX_HOLD, 4, maximum transfers per grant before forced release (1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N_REQ  per-requester request; held high while the requester has data.
- data_in  input  N_REQ*DATA_W  requester data, packed; requester i occupies bits [i*DATA_W +: DATA_W].
- bus_ready  input  1  bus consumer accepts the word this cycle.
- grant  output  N_REQ  one-hot registered grant.
- sel  output  SEL_W  registered binary index of the current owner; drives the mux S inputs.
- bus_out  output  DATA_W  muxed data word.
- bus_valid  output  1  bus_out holds a valid word.
- ack  output  N_REQ  one-hot, one-cycle pulse to the owner when its word is accepted.

Behaviour:
- One clock. Reset is asynchronous and active-high on rst.
- Reset values: state=IDLE, grant=0, sel=0, ptr=0, hold_cnt=0. bus_valid=0, bus_out=0, ack=0 (all combinational from state).
- States are IDLE and OWN.
- IDLE, no req bit set: stay in IDLE.
- IDLE, any req bit set:
  - Winner is the first set bit scanning ptr, ptr+1, ..., wrapping modulo N_REQ.
  - Next edge: grant=onehot(winner), sel=winner, hold_cnt=0, state=OWN.
  - Latency from req rising to grant is 1 cycle.
- OWN outputs:
  - bus_valid = req[sel].
  - bus_out = data_in[sel] when in OWN, else 0.
  - xfer = bus_valid & bus_ready.
  - ack[sel] = xfer.
- OWN, on xfer: hold_cnt increments.
- OWN, release condition: req[sel]==0, or (xfer and hold_cnt==MAX_HOLD-1).
- On release, next edge: state=IDLE, grant=0, ptr=(sel+1) mod N_REQ. sel keeps its last value.
- Release always leaves one IDLE bubble cycle with grant=0 before the next grant, including when the same requester wins again.
- Owner deasserting req in the same cycle as xfer: no transfer (bus_valid is already 0); release.
- bus_ready high while bus_valid is low: ignored. No ack, no count.
- Requests from non-owners during OWN are ignored until the next IDLE.
- hold_cnt is 4 bits and never exceeds MAX_HOLD-1.
- ptr wraps from N_REQ-1 to 0.
- rst asserted mid-transfer: all outputs go to reset values immediately, without waiting for a clock. An in-flight word is dropped with no ack.
- bus_valid is never high while grant==0.

Test Plan:
- Reset then single requester: req=4'b0100, data_in[2]=8'hA5, bus_ready=1 → grant=4'b0100 and sel=2 one cycle after req. bus_out=8'hA5, bus_valid=1, ack=4'b0100 each cycle. Forced release after 4 acks, 1 idle cycle, then re-grant to requester 2.
- Round-robin fairness: req=4'b1111 held, bus_ready=1 → owners in order 0,1,2,3,0. Each gets exactly 4 acks. grant=0 for exactly 1 cycle between owners.
- Backpressure: owner 1, bus_ready low for 3 cycles → bus_valid=1 and bus_out stable, ack=0, hold_cnt unchanged. Transfers resume when bus_ready=1.
- Early release: owner 3 drops req after 2 acks → next edge state=IDLE, grant=0, ptr=0. A pending req[0] is granted on the following edge.
- Asynchronous reset mid-grant: assert rst between clock edges while grant=4'b0010 → grant=0, bus_valid=0, ack=0 before the next edge. After release, with req=4'b0010, requester 1 is regranted with ptr=0.
- Wrap and skip: ptr=3, req=4'b0101 → winner is 0. After release, ptr=1 → next winner is 2.
